pcm_player: RTL

Parametrised PCM playback engine: it fetches unsigned samples from an external synchronous sample memory, applies a volume scale, and drives a 1-bit PWM audio output. It runs on a single clock and uses an internal period counter instead of derived clocks, so no clock-domain synchronisers are needed. It supports programmable start and end addresses, one-shot or loop mode, stop/abort, a done pulse and a busy flag. The top level instantiates it between the sample memory and the board's audio PWM pin.

---
 rtl/pcm_player.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pcm_player.sv
// PCM playback engine: fetches samples from synchronous memory, scales by volume,
// and drives a registered PWM output with a period-boundary sequencer.
module pcm_player #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int REP    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [3:0]        volume,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              pwm
);

    localparam int              RW       = (REP > 1) ? $clog2(REP) : 1;
    localparam logic [RW-1:0]   REP_LAST = RW'(REP - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, LAST} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   pwm_cnt, cur_sample, next_sample;
    logic [RW-1:0]       rep_cnt;
    logic [ADDR_W-1:0]   addr, sa_q, ea_q;
    logic                loop_q;
    logic                pwm_wrap, bnd, accept, abort;
    logic [4:0]          gain;
    logic [DATA_W+3:0]   prod;

    assign pwm_wrap = &pwm_cnt;
    assign bnd      = pwm_wrap && (rep_cnt == REP_LAST);
    assign accept   = (state == IDLE) && start && !stop;
    assign abort    = (state != IDLE) && stop;

    // volume+1 spans 1..16, so mem_data*16 still fits in DATA_W+4 bits
    assign gain = {1'b0, volume} + 5'd1;
    assign prod = {4'b0, mem_data} * {{(DATA_W-1){1'b0}}, gain};

    assign busy      = (state != IDLE);
    assign mem_rd_en = (state == FETCH);
    assign mem_addr  = addr;

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:  if (accept) state_nx = FETCH;
                FETCH: state_nx = WAIT;
                WAIT:  state_nx = HOLD;
                HOLD:  if (bnd) state_nx = (addr == ea_q && !loop_q) ? LAST : FETCH;
                LAST:  if (bnd) begin
                           state_nx = IDLE;
                           done     = 1'b1;
                       end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            pwm_cnt     <= '0;
            rep_cnt     <= '0;
            addr        <= '0;
            sa_q        <= '0;
            ea_q        <= '0;
            loop_q      <= 1'b0;
            next_sample <= '0;
            cur_sample  <= '0;
            cur_addr    <= '0;
            pwm         <= 1'b0;
        end else begin
            state <= state_nx;
            pwm   <= (pwm_cnt < cur_sample);

            // Start realigns the period so the first boundary lands exactly P clocks later
            if (accept) begin
                pwm_cnt <= '0;
                rep_cnt <= '0;
                addr    <= start_addr;
                sa_q    <= start_addr;
                ea_q    <= end_addr;
                loop_q  <= loop_en;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
                if (bnd)
                    rep_cnt <= '0;
                else if (pwm_wrap)
                    rep_cnt <= rep_cnt + 1'b1;
            end

            if (state == WAIT)
                next_sample <= prod[DATA_W+3:4];

            if (abort) begin
                cur_sample <= '0;
            end else if (bnd && state == HOLD) begin
                cur_sample <= next_sample;
                cur_addr   <= addr;
                if (addr != ea_q)
                    addr <= addr + 1'b1;
                else if (loop_q)
                    addr <= sa_q;
            end else if (bnd && state == LAST) begin
                cur_sample <= '0;
            end
        end
    end

endmodule
